// File: rtl/pipeline_ctrl_seq_pkg.sv
// Shared types and defaults for the 5-stage pipeline sequencer.
package pipeline_ctrl_seq_pkg;

  localparam int unsigned MEM_TIMEOUT_DEF = 64;
  localparam int unsigned CNT_W_DEF       = 16;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } state_e;

  // Per-stage register enables and bubble controls, MSB = PC/nPC enable
  typedef struct packed {
    logic pc_le;
    logic ifid_le;
    logic idex_le;
    logic exmem_le;
    logic memwb_le;
    logic flush_d;
    logic flush_e;
    logic flush_w;
  } stage_ctrl_t;

  localparam stage_ctrl_t CTRL_RUN    = stage_ctrl_t'(8'b11111_000);
  localparam stage_ctrl_t CTRL_LU     = stage_ctrl_t'(8'b00111_010);
  localparam stage_ctrl_t CTRL_ANNUL  = stage_ctrl_t'(8'b11111_100);
  localparam stage_ctrl_t CTRL_FREEZE = stage_ctrl_t'(8'b00000_001);
  localparam stage_ctrl_t CTRL_HALT   = stage_ctrl_t'(8'b00000_000);

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipeline_ctrl_seq.sv
// Pipeline sequencer: merges load-use stalls, EX redirects and the data-memory
// handshake into one set of stage enables/bubbles, with stall/flush counters.
module pipeline_ctrl_seq
  import pipeline_ctrl_seq_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             lu_hazard,
  input  logic             cti_taken_EX,
  input  logic             annul_EX,
  input  logic             mem_req_MEM,
  input  logic             mem_ready,
  output logic             pc_le,
  output logic             ifid_le,
  output logic             idex_le,
  output logic             exmem_le,
  output logic             memwb_le,
  output logic             flush_D,
  output logic             flush_E,
  output logic             flush_W,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  state_e            state_q;
  state_e            state_d;
  logic [WAIT_W-1:0] wait_q;
  logic [WAIT_W-1:0] wait_d;
  logic              mem_err_q;
  logic              mem_err_d;
  stage_ctrl_t       ctrl;

  // Next-state and stage-control decode; reset forces free-running controls
  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    mem_err_d = mem_err_q;
    ctrl      = CTRL_RUN;
    if (rst_n) begin
      unique case (state_q)
        RUN: begin
          if (mem_req_MEM && !mem_ready) begin
            ctrl    = CTRL_FREEZE;
            state_d = MEM_WAIT;
            wait_d  = '0;
          end else if (cti_taken_EX && annul_EX) begin
            // Delay slot in ID is squashed, so its load-use stall is moot
            ctrl = CTRL_ANNUL;
          end else if (lu_hazard) begin
            ctrl = CTRL_LU;
          end
        end
        MEM_WAIT: begin
          if (mem_ready) begin
            state_d = RUN;
            wait_d  = '0;
          end else begin
            ctrl = CTRL_FREEZE;
            if (wait_q == WAIT_LAST) begin
              state_d   = ERR;
              mem_err_d = 1'b1;
              wait_d    = '0;
            end else begin
              wait_d = wait_q + WAIT_W'(1);
            end
          end
        end
        ERR: begin
          ctrl      = CTRL_HALT;
          mem_err_d = 1'b1;
        end
        default: begin
          ctrl    = CTRL_HALT;
          state_d = RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RUN;
      wait_q    <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      mem_err_q <= mem_err_d;
    end
  end

  assign pc_le    = ctrl.pc_le;
  assign ifid_le  = ctrl.ifid_le;
  assign idex_le  = ctrl.idex_le;
  assign exmem_le = ctrl.exmem_le;
  assign memwb_le = ctrl.memwb_le;
  assign flush_D  = ctrl.flush_d;
  assign flush_E  = ctrl.flush_e;
  assign flush_W  = ctrl.flush_w;
  assign mem_err  = mem_err_q;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (~ctrl.pc_le),
    .cnt   (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (ctrl.flush_d | ctrl.flush_e),
    .cnt   (flush_cnt)
  );

endmodule

// File: tb/tb_pipeline_ctrl_seq.sv
// Scoreboard bench for pipeline_ctrl_seq (MEM_TIMEOUT=4, CNT_W=4).
module tb_pipeline_ctrl_seq;

  localparam int unsigned CNT_W = 4;

  // Control vector order: pc, ifid, idex, exmem, memwb, flush_D, flush_E, flush_W
  localparam logic [7:0] C_RUN = 8'b11111_000;
  localparam logic [7:0] C_LU  = 8'b00111_010;
  localparam logic [7:0] C_ANN = 8'b11111_100;
  localparam logic [7:0] C_FRZ = 8'b00000_001;
  localparam logic [7:0] C_ERR = 8'b00000_000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic lu_hazard = 1'b0, cti_taken_EX = 1'b0, annul_EX = 1'b0;
  logic mem_req_MEM = 1'b0, mem_ready = 1'b0;
  logic pc_le, ifid_le, idex_le, exmem_le, memwb_le;
  logic flush_D, flush_E, flush_W, mem_err;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  pipeline_ctrl_seq #(.MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .lu_hazard    (lu_hazard),
    .cti_taken_EX (cti_taken_EX),
    .annul_EX     (annul_EX),
    .mem_req_MEM  (mem_req_MEM),
    .mem_ready    (mem_ready),
    .pc_le        (pc_le),
    .ifid_le      (ifid_le),
    .idex_le      (idex_le),
    .exmem_le     (exmem_le),
    .memwb_le     (memwb_le),
    .flush_D      (flush_D),
    .flush_E      (flush_E),
    .flush_W      (flush_W),
    .mem_err      (mem_err),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
  );

  always #5 clk = ~clk;

  string      name_q[$];
  logic [16:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  // Monitor: compare every pending expectation at the falling edge
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      string       nm;
      logic [16:0] exp_v;
      logic [16:0] got_v;
      nm    = name_q.pop_front();
      exp_v = exp_q.pop_front();
      got_v = {pc_le, ifid_le, idex_le, exmem_le, memwb_le, flush_D, flush_E, flush_W,
               mem_err, stall_cnt, flush_cnt};
      n_checks++;
      if (got_v === exp_v) begin
        n_pass++;
      end else begin
        $display("FAIL %s: got ctrl=%b err=%b stall=%0d flush=%0d, want ctrl=%b err=%b stall=%0d flush=%0d",
                 nm, got_v[16:9], got_v[8], got_v[7:4], got_v[3:0],
                 exp_v[16:9], exp_v[8], exp_v[7:4], exp_v[3:0]);
      end
    end
  end

  // Drive one cycle of inputs just after the rising edge and queue its expectation
  task automatic step(input string nm, input logic rst, input logic lu, input logic cti,
                      input logic an, input logic req, input logic rdy,
                      input logic [7:0] ctrl, input logic err,
                      input int unsigned st, input int unsigned fl);
    @(posedge clk);
    #1;
    rst_n        = rst;
    lu_hazard    = lu;
    cti_taken_EX = cti;
    annul_EX     = an;
    mem_req_MEM  = req;
    mem_ready    = rdy;
    name_q.push_back(nm);
    exp_q.push_back({ctrl, err, 4'(st), 4'(fl)});
  endtask

  initial begin
    // Reset holds free-running controls even with a hazard asserted
    step("rst_idle",    0, 0, 0, 0, 0, 0, C_RUN, 0, 0, 0);
    step("rst_lu_held", 0, 1, 0, 0, 0, 0, C_RUN, 0, 0, 0);
    step("idle",        1, 0, 0, 0, 0, 0, C_RUN, 0, 0, 0);
    // Load-use and CTI interactions
    step("lu_stall",    1, 1, 0, 0, 0, 0, C_LU,  0, 0, 0);
    step("lu_after",    1, 0, 0, 0, 0, 0, C_RUN, 0, 1, 1);
    step("cti_ann_lu",  1, 1, 1, 1, 0, 0, C_ANN, 0, 1, 1);
    step("cti_nann_lu", 1, 1, 1, 0, 0, 0, C_LU,  0, 1, 2);
    step("cti_plain",   1, 0, 1, 0, 0, 0, C_RUN, 0, 2, 3);
    step("mem_hit",     1, 0, 0, 0, 1, 1, C_RUN, 0, 2, 3);
    // Memory wait: three frozen cycles, release on the fourth
    step("mw_enter",    1, 0, 0, 0, 1, 0, C_FRZ, 0, 2, 3);
    step("mw_wait1",    1, 0, 0, 0, 1, 0, C_FRZ, 0, 3, 3);
    step("mw_wait2_lu", 1, 1, 0, 0, 1, 0, C_FRZ, 0, 4, 3);
    step("mw_release",  1, 0, 0, 0, 1, 1, C_RUN, 0, 5, 3);
    step("mw_after",    1, 0, 0, 0, 0, 0, C_RUN, 0, 5, 3);
    step("rst_b",       0, 0, 0, 0, 0, 0, C_RUN, 0, 0, 0);
    // Timeout into ERR after four wait cycles
    step("to_enter",    1, 0, 0, 0, 1, 0, C_FRZ, 0, 0, 0);
    step("to_wait0",    1, 0, 0, 0, 1, 0, C_FRZ, 0, 1, 0);
    step("to_wait1",    1, 0, 0, 0, 1, 0, C_FRZ, 0, 2, 0);
    step("to_wait2",    1, 0, 0, 0, 1, 0, C_FRZ, 0, 3, 0);
    step("to_wait3",    1, 0, 0, 0, 1, 0, C_FRZ, 0, 4, 0);
    step("err_entry",   1, 0, 0, 0, 1, 0, C_ERR, 1, 5, 0);
    step("err_ready",   1, 0, 0, 0, 1, 1, C_ERR, 1, 6, 0);
    step("err_lu_cti",  1, 1, 1, 1, 0, 0, C_ERR, 1, 7, 0);
    step("err_rst",     0, 0, 0, 0, 0, 0, C_RUN, 0, 0, 0);
    step("err_rst_hold",0, 0, 0, 0, 0, 0, C_RUN, 0, 0, 0);
    // Reset asserted mid-wait releases the pipeline without a clock edge
    step("mw2_enter",   1, 0, 0, 0, 1, 0, C_FRZ, 0, 0, 0);
    step("mw2_wait",    1, 0, 0, 0, 1, 0, C_FRZ, 0, 1, 0);
    step("mw2_rst",     0, 0, 0, 0, 1, 0, C_RUN, 0, 0, 0);
    step("mw2_run",     1, 0, 0, 0, 0, 0, C_RUN, 0, 0, 0);
    // Twenty back-to-back load-use stalls saturate both counters at 15
    for (int i = 0; i < 20; i++) begin
      step($sformatf("sat_lu%0d", i), 1, 1, 0, 0, 0, 0, C_LU, 0,
           (i > 15) ? 15 : i, (i > 15) ? 15 : i);
    end
    step("sat_after",   1, 0, 0, 0, 0, 0, C_RUN, 0, 15, 15);
    step("sat_hold",    1, 0, 0, 0, 0, 0, C_RUN, 0, 15, 15);

    // Let the monitor drain, bounded
    for (int k = 0; k < 5 && exp_q.size() != 0; k++) @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_pass++;
    end else begin
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
